// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU stage, LSB-first result burst with carry/zero/neg flags
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               opcode,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic                     abort,
  output logic                     alu_result,
  output logic                     alu_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     busy,
  output logic                     done,
  output logic                     carry_flag,
  output logic                     zero_flag,
  output logic                     neg_flag
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             zero_acc;
  logic             accept;
  logic             last_bit;
  logic             b_eff;
  logic             is_arith;
  logic             res_bit;
  logic             carry_nxt;

  assign accept   = start && (state != RUN);
  assign last_bit = (bit_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        // abort wins even on the final bit
        if (abort)         next_state = IDLE;
        else if (last_bit) next_state = DONE;
      end
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Serial full adder; SUB inverts B and relies on carry_q preset to 1.
  always_comb begin
    b_eff     = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);
    carry_nxt = is_arith & ((a_sh[0] & b_eff) | (carry_q & (a_sh[0] ^ b_eff)));
    res_bit   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_ADC: res_bit = a_sh[0] ^ b_eff ^ carry_q;
      OP_AND:  res_bit = a_sh[0] & b_sh[0];
      OP_OR:   res_bit = a_sh[0] | b_sh[0];
      OP_XOR:  res_bit = a_sh[0] ^ b_sh[0];
      OP_PASS: res_bit = b_sh[0];
      default: res_bit = 1'b0;
    endcase
  end

  assign alu_valid  = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign alu_result = alu_valid & res_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      zero_acc   <= 1'b0;
      bit_count  <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
    end else if (accept) begin
      a_sh      <= op_a;
      b_sh      <= op_b;
      op_q      <= opcode;
      carry_q   <= (opcode == OP_SUB) | ((opcode == OP_ADC) & carry_flag);
      zero_acc  <= 1'b1;
      bit_count <= '0;
    end else if (state == RUN) begin
      if (abort) begin
        bit_count <= '0;
      end else begin
        a_sh     <= a_sh >> 1;
        b_sh     <= b_sh >> 1;
        carry_q  <= carry_nxt;
        zero_acc <= zero_acc & ~res_bit;
        if (last_bit) begin
          bit_count  <= '0;
          carry_flag <= carry_nxt;
          zero_flag  <= zero_acc & ~res_bit;
          neg_flag   <= res_bit;
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end

endmodule
